sync_fifo_thr: RTL
==================

SYNC_FIFO_THR -- requirements
Module: sync_fifo_thr

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, address width; DEPTH = 2**AWIDTH entries.
REQ-002 SHALL have parameter DWIDTH, default 8, data word width.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-2, almost_full asserts when count >= AFULL_THR.
REQ-004 SHALL have parameter AEMPTY_THR, default 2, almost_empty asserts when count <= AEMPTY_THR.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: write_en in 1, write request; data_in in DWIDTH, write data.
REQ-007 SHALL have ports: read_en in 1, read request; data_out out DWIDTH, read data.
REQ-008 SHALL have ports: full, empty, almost_full, almost_empty, all out 1, status flags.
REQ-009 SHALL have ports: count out AWIDTH+1, occupancy 0..DEPTH.
REQ-010 SHALL have ports: overflow, underflow, both out 1, one-cycle error pulses.

Function
REQ-011 Write accepted on a clk rising edge when write_en && (!full || read accepted the same cycle).
REQ-012 Read accepted on a clk rising edge when read_en && !empty.
REQ-013 Simultaneous accepted read and write: both proceed; count unchanged. Writing when full is legal only with a concurrent accepted read.
REQ-014 Pointers are AWIDTH wide and wrap modulo DEPTH with no special case.
REQ-015 count SHALL be registered: +1 on write-only, -1 on read-only, otherwise held.
REQ-016 Flags SHALL be decoded from count: empty = (count==0); full = (count==DEPTH); almost_* per REQ-003/004.
REQ-017 All flags SHALL update in the cycle after the accepted operation's edge, with no combinational path from write_en or read_en.
REQ-018 overflow SHALL pulse high for 1 cycle after an edge where write_en && full && no read was accepted; data is dropped and state is unchanged.
REQ-019 underflow SHALL pulse high for 1 cycle after an edge where read_en && empty; data_out holds.
REQ-020 Standard mode: data_out SHALL be registered from the head entry on an accepted read (1-cycle latency) and hold otherwise.

Reset
REQ-021 rst_n low SHALL immediately clear: pointers 0, count 0, data_out 0, overflow and underflow 0.
REQ-022 While rst_n is low: empty=1, almost_empty=1, full=0, almost_full=0 (almost_full=0 requires AFULL_THR>0).
REQ-023 Reset mid-operation SHALL discard all stored entries. Memory contents are not cleared and are not observable afterwards.
REQ-024 Release of rst_n is synchronous to clk in the integrating system; the first accepted write is on the first edge after release.

Configuration
REQ-025 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-026 SYNC_FIFO_FWFT_EN defined: data_out SHALL present the head entry whenever !empty, with no read latency; read_en pops the entry and the next head appears the following cycle.
REQ-027 SYNC_FIFO_FWFT_EN defined: data_out value is don't-care while empty.
REQ-028 SYNC_FIFO_FWFT_EN undefined: REQ-020 behaviour applies.
REQ-029 Flags, count and error pulses SHALL be identical in both modes.

Structure
REQ-030 Package fifo_pkg SHALL hold the default width constants and a function for the count width (AWIDTH+1).
REQ-031 Storage SHALL be a sub-module fifo_mem: DEPTH x DWIDTH, synchronous write, asynchronous read, no reset.
REQ-032 Control, pointers, count and flags SHALL live in sync_fifo_thr.
REQ-033 Parameter legality (AEMPTY_THR < AFULL_THR <= DEPTH) SHALL be checked at elaboration.

Verification
REQ-034 Reset, then 16 writes 0x00..0x0F (AWIDTH=4) -> full=1 and count=16 after the last edge; almost_full first asserts at count 14.
REQ-035 Full FIFO, write 0xAA with no read -> overflow pulses 1 cycle; count stays 16; later reads return 0x00..0x0F in order.
REQ-036 Full FIFO, simultaneous read and write 0x55 -> count stays 16; 0x55 is read out 16th.
REQ-037 Empty FIFO, read_en=1 -> underflow pulses 1 cycle; data_out unchanged; empty stays 1.
REQ-038 Wrap test, 40 interleaved write/read pairs -> data order preserved across pointer wrap; count never exceeds 16.
REQ-039 rst_n low for 1 cycle with count=7 -> count=0, empty=1 immediately. Repeat REQ-034 in both SYNC_FIFO_FWFT_EN builds: FWFT shows 0x00 on data_out one cycle after the first write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, operation encoding and width helpers for the threshold FIFO.
package fifo_pkg;

    localparam int unsigned DEF_AWIDTH = 4;
    localparam int unsigned DEF_DWIDTH = 8;

    // Encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OpIdle  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    // The count has to represent 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int unsigned count_width(input int unsigned awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_thr_if.sv
// Handshake, data and status bundle between a FIFO user (master) and sync_fifo_thr (slave).
interface sync_fifo_thr_if
    import fifo_pkg::*;
#(
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH
);

    logic              write_en;
    logic [DWIDTH-1:0] data_in;
    logic              read_en;
    logic [DWIDTH-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write_en, data_in, read_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have 1-cycle latency.
module sync_fifo_thr
    import fifo_pkg::*;
#(
    parameter int unsigned AWIDTH     = DEF_AWIDTH,
    parameter int unsigned DWIDTH     = DEF_DWIDTH,
    parameter int unsigned AFULL_THR  = (1 << AWIDTH) - 2,
    parameter int unsigned AEMPTY_THR = 2
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_thr_if.slave bus
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned CW    = count_width(AWIDTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

    if (!((AEMPTY_THR < AFULL_THR) && (AFULL_THR <= DEPTH))) begin : g_param_check
        $error("sync_fifo_thr: thresholds must satisfy AEMPTY_THR < AFULL_THR <= DEPTH");
    end

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full, empty;
    logic              rd_acc, wr_acc;
    fifo_op_e          op;
    logic [DWIDTH-1:0] head;

    // Flags come only from the count register, so there is no path from the request inputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign rd_acc = bus.read_en && !empty;
    assign wr_acc = bus.write_en && (!full || rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.write_en && full && !rd_acc;
        underflow_d = bus.read_en && empty;

        if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);

        unique case (op)
            OpWrite: count_d = count_q + CW'(1);
            OpRead:  count_d = count_q - CW'(1);
            OpIdle,
            OpBoth:  count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry falls through; masked while empty so stale memory never leaks out.
    assign bus.data_out = empty ? '0 : head;
`else
    logic [DWIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= head;
        end
    end

    assign bus.data_out = data_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
